crc_8: RTL and testbench

- Fully pipelined, parallel CRC-8 engine over a 72-bit word.
- Each cycle it accepts one 72-bit message M and emits its 8-bit CRC remainder a fixed 10 clock edges later; throughput is one word per clock.
- M is normally {64-bit payload, 8-bit CRC field}.
  - With the field = 8'h00, the output is the payload's CRC.
  - With the field = that CRC, the output is 8'h00 (check mode).
- Used in datapath integrity generation/check stages.

---
 rtl/crc8_pkg.sv | 24 ++
 rtl/crc_8_if.sv | 11 +
 rtl/crc8_byte_stage.sv | 49 ++++
 rtl/crc_8.sv | 61 ++++++
 tb/tb_crc_8.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/crc8_pkg.sv
// Shared constants and the per-byte remainder fold
// used by the pipelined CRC-8 engine.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int MSG_W = 72;
  localparam int NUM_BYTES = 9;

  // rem' = (rem * x^8 + data) mod G; starting from 0 this is M mod G
  function automatic logic [7:0] crc8_byte_step(
    input logic [7:0] crc,
    input logic [7:0] data,
    input logic [7:0] poly = CRC8_POLY
  );
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ poly;
      else      c = {c[6:0], 1'b0};
    end
    return c ^ data;
  endfunction

endpackage

// File: rtl/crc_8_if.sv
// Message/remainder bundle for the CRC-8 engine.
// Master drives the word, slave returns the remainder.
interface crc_8_if
  import crc8_pkg::*;
;
  logic [MSG_W-1:0] m;
  logic [7:0]       crc;

  modport master (output m, input crc);
  modport slave  (input m, output crc);
endinterface

// File: rtl/crc8_byte_stage.sv
// One pipeline rank: folds the leading byte into the
// running remainder and forwards the unprocessed bytes.
module crc8_byte_stage
  import crc8_pkg::*;
#(
  parameter int         REM_BYTES = 1,
  parameter logic [7:0] POLY      = CRC8_POLY,
  localparam int IN_W  = 8 * REM_BYTES,
  localparam int OUT_W =
    (REM_BYTES > 1) ? 8 * (REM_BYTES - 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rem_i,
  input  logic [IN_W-1:0]  bytes_i,
  output logic [7:0]       rem_o,
  output logic [OUT_W-1:0] bytes_o
);

  logic [7:0] rem_d;
  logic [7:0] rem_q;

  assign rem_d =
    crc8_byte_step(rem_i, bytes_i[IN_W-1 -: 8], POLY);

  always_ff @(posedge clk) begin
    if (!rst) rem_q <= '0;
    else      rem_q <= rem_d;
  end

  assign rem_o = rem_q;

  if (REM_BYTES > 1) begin : g_carry
    logic [OUT_W-1:0] bytes_d;
    logic [OUT_W-1:0] bytes_q;

    assign bytes_d = bytes_i[OUT_W-1:0];

    always_ff @(posedge clk) begin
      if (!rst) bytes_q <= '0;
      else      bytes_q <= bytes_d;
    end

    assign bytes_o = bytes_q;
  end else begin : g_last
    assign bytes_o = 1'b0;
  end

endmodule

// File: rtl/crc_8.sv
// Fully pipelined CRC-8 over a 72-bit word: an input
// rank followed by nine byte-fold ranks.
module crc_8
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSG_W-1:0] M,
  output logic [7:0]       CRC_out
);

  logic [MSG_W-1:0] m_q;

  always_ff @(posedge clk) begin
    if (!rst) m_q <= '0;
    else      m_q <= M;
  end

  for (genvar i = 1; i <= NUM_BYTES; i++) begin : g_rank
    localparam int R  = NUM_BYTES + 1 - i;
    localparam int OW = (R > 1) ? 8 * (R - 1) : 1;

    logic [7:0]    rem_q;
    logic [OW-1:0] bytes_q;

    if (i == 1) begin : g_first
      crc8_byte_stage #(
        .REM_BYTES (R),
        .POLY      (POLY)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .rem_i   (8'h00),
        .bytes_i (m_q),
        .rem_o   (rem_q),
        .bytes_o (bytes_q)
      );
    end else begin : g_next
      crc8_byte_stage #(
        .REM_BYTES (R),
        .POLY      (POLY)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .rem_i   (g_rank[i-1].rem_q),
        .bytes_i (g_rank[i-1].bytes_q),
        .rem_o   (rem_q),
        .bytes_o (bytes_q)
      );
    end
  end

  // Last rank has no bytes left to carry
  logic tail_unused;
  assign tail_unused = ^g_rank[NUM_BYTES].bytes_q;

  assign CRC_out = g_rank[NUM_BYTES].rem_q;

endmodule

// File: tb/tb_crc_8.sv
// Self-checking bench for crc_8: expected remainders are
// queued as words are driven and popped as results emerge.
module tb_crc_8;
  import crc8_pkg::*;

  logic clk = 1'b0;
  logic rst;

  crc_8_if bus ();

  always #5 clk = ~clk;

  crc_8 #(.POLY(8'h07)) dut (
    .clk     (clk),
    .rst     (rst),
    .M       (bus.m),
    .CRC_out (bus.crc)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  localparam logic [63:0] P0 = 64'h1234567890ABCDEF;
  localparam logic [63:0] P1 = 64'hFEDCBA9876543210;
  localparam logic [63:0] P2 = 64'h0F0F0F0F0F0F0F0F;

  // Reference: bitwise long division of M(x) by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [71:0] m);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    for (int i = 71; i >= 0; i--) begin
      fb = r[7];
      r  = {r[6:0], m[i]};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [71:0] rnd72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  // Drive one word, clock it in, and report what is due now
  task automatic tick(
    input  logic [71:0] m,
    input  logic        r,
    input  logic        ovr,
    input  logic [7:0]  ovr_val,
    output logic        due,
    output logic [7:0]  exp
  );
    @(negedge clk);
    bus.m = m;
    rst   = r;
    @(posedge clk);
    due = 1'b0;
    exp = 8'h00;
    if (!r) begin
      exp_q.delete();
      repeat (9) exp_q.push_back(8'h00);
      due = 1'b1;
    end else begin
      exp_q.push_back(ovr ? ovr_val : ref_crc(m));
      if (exp_q.size() >= 10) begin
        exp = exp_q.pop_front();
        due = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic d;
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      tick(rnd72(), 1'b0, 1'b0, 8'h00, d, e);
      if (d) begin
        checks++;
        if (bus.crc !== 8'h00) begin
          errors++;
          $display("FAIL reset_hold: CRC_out=%h expected 00",
                   bus.crc);
        end
      end
    end
    tick({P0, 8'h00}, 1'b1, 1'b1, 8'hFA, d, e);
    for (int i = 0; i < 10; i++) begin
      if (d) begin
        checks++;
        if (bus.crc !== e) begin
          errors++;
          $display("FAIL reset_release[%0d]: CRC_out=%h expected %h",
                   i, bus.crc, e);
        end
      end
      tick(72'h0, 1'b1, 1'b1, 8'h00, d, e);
    end
  endtask

  task automatic test_generate();
    logic d;
    logic [7:0] e;
    logic [71:0] w [3];
    logic [7:0]  x [3];
    w = '{{P0, 8'h00}, {P1, 8'h00}, {P2, 8'h00}};
    x = '{8'hFA, 8'hC9, 8'hC3};
    for (int k = 0; k < 3; k++) begin
      tick(w[k], 1'b1, 1'b1, x[k], d, e);
      for (int i = 0; i < 10; i++) begin
        if (d) begin
          checks++;
          if (bus.crc !== e) begin
            errors++;
            $display("FAIL generate%0d: CRC_out=%h expected %h",
                     k, bus.crc, e);
          end
        end
        tick(72'h0, 1'b1, 1'b1, 8'h00, d, e);
      end
    end
  endtask

  task automatic test_check();
    logic d;
    logic [7:0] e;
    logic [71:0] w [3];
    w = '{{P0, 8'hFA}, {P1, 8'hC9}, {P2, 8'hC3}};
    for (int k = 0; k < 3; k++) begin
      tick(w[k], 1'b1, 1'b1, 8'h00, d, e);
      for (int i = 0; i < 10; i++) begin
        if (d) begin
          checks++;
          if (bus.crc !== e) begin
            errors++;
            $display("FAIL check%0d: CRC_out=%h expected %h",
                     k, bus.crc, e);
          end
        end
        tick(72'h1, 1'b1, 1'b1, 8'h01, d, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic d;
    logic [7:0] e;
    logic [71:0] w [6];
    logic [7:0]  x [6];
    w = '{{P0, 8'h00}, {P0, 8'hFA}, {P1, 8'h00},
          {P1, 8'hC9}, {P2, 8'h00}, {P2, 8'hC3}};
    x = '{8'hFA, 8'h00, 8'hC9, 8'h00, 8'hC3, 8'h00};
    for (int k = 0; k < 16; k++) begin
      if (k < 6) tick(w[k], 1'b1, 1'b1, x[k], d, e);
      else       tick(72'h0, 1'b1, 1'b1, 8'h00, d, e);
      if (d) begin
        checks++;
        if (bus.crc !== e) begin
          errors++;
          $display("FAIL stream[%0d]: CRC_out=%h expected %h",
                   k, bus.crc, e);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic d;
    logic [7:0] e;
    for (int k = 0; k < 5; k++) begin
      tick(rnd72(), 1'b1, 1'b0, 8'h00, d, e);
      if (d) begin
        checks++;
        if (bus.crc !== e) begin
          errors++;
          $display("FAIL mid_pre[%0d]: CRC_out=%h expected %h",
                   k, bus.crc, e);
        end
      end
    end
    tick(rnd72(), 1'b0, 1'b0, 8'h00, d, e);
    checks++;
    if (bus.crc !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst: CRC_out=%h expected 00", bus.crc);
    end
    for (int k = 0; k < 24; k++) begin
      if (k == 12)      tick({P1, 8'h00}, 1'b1, 1'b1, 8'hC9, d, e);
      else if (k == 13) tick({P2, 8'hC3}, 1'b1, 1'b1, 8'h00, d, e);
      else              tick(72'h0, 1'b1, 1'b1, 8'h00, d, e);
      if (d) begin
        checks++;
        if (bus.crc !== e) begin
          errors++;
          $display("FAIL mid_post[%0d]: CRC_out=%h expected %h",
                   k, bus.crc, e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic d;
    logic [7:0] e;
    for (int k = 0; k < 10012; k++) begin
      if (k == 0)          tick(72'h0, 1'b1, 1'b1, 8'h00, d, e);
      else if (k == 1)     tick(72'h1, 1'b1, 1'b1, 8'h01, d, e);
      else if (k < 10002)  tick(rnd72(), 1'b1, 1'b0, 8'h00, d, e);
      else                 tick(72'h0, 1'b1, 1'b1, 8'h00, d, e);
      if (d) begin
        checks++;
        if (bus.crc !== e) begin
          errors++;
          $display("FAIL random[%0d]: CRC_out=%h expected %h",
                   k, bus.crc, e);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    bus.m = '0;
    test_reset();
    test_generate();
    test_check();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
